// File: rtl/uart_tx_sequencer.sv
// uart_tx_sequencer: inits a 16550 UART over the system bus, then feeds its THR from two round-robin requesters (optional UART_SEQ_READ_TIMEOUT_EN read timeout)
module uart_tx_sequencer #(
  parameter logic [31:0] uartBaseAddress = 32'h50000000,
  parameter logic [15:0] baudDivisor = 16'd27,
  parameter logic [7:0] lineControl = 8'h03,
  parameter logic [4:0] txFifoDepth = 5'd16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0Valid,
  input  logic [7:0]  req0Data,
  output logic        req0Ack,
  input  logic        req1Valid,
  input  logic [7:0]  req1Data,
  output logic        req1Ack,
  output logic        requestTransactionOut,
  input  logic        transactionGrantedIn,
  output logic        beginTransactionOut,
  output logic        endTransactionOut,
  output logic        readNWriteOut,
  output logic [31:0] addressDataOut,
  output logic [3:0]  byteEnablesOut,
  output logic [7:0]  burstSizeOut,
  output logic        dataValidOut,
  input  logic [31:0] addressDataIn,
  input  logic        dataValidIn,
  input  logic        endTransactionIn,
  input  logic        busErrorIn,
  output logic        initDone,
  output logic        busErrorSticky
);
  typedef enum logic [2:0] {IDLE, REQ, ADDR, DATA, WEND, RWAIT} state_t;
  typedef enum logic [2:0] {INIT0, INIT1, INIT2, INIT3, ARB, LSR, THR} step_t;
  state_t state_q, state_d;
  step_t step_q, step_d;
  logic done_q, done_d, err_q, err_d, ptr_q, ptr_d, win_q, win_d;
  logic pick, tmo, fault, is_rd;
  logic [4:0] cred_q, cred_d;
  logic [7:0] byte_q, byte_d, rdat_q, rdat_d, wdat, rd_lane, lsr;
  logic [2:0] off;
`ifdef UART_SEQ_READ_TIMEOUT_EN
  logic [9:0] tmo_q, tmo_d;
  // counts cycles spent waiting for the slave to end a read
  always_comb begin
    tmo_d = state_q == RWAIT ? tmo_q + 10'd1 : 10'd0;
    tmo = state_q == RWAIT && tmo_q == 10'd1022 && !endTransactionIn;
  end
  // timeout counter register
  always_ff @(posedge clock) tmo_q <= reset ? 10'd0 : tmo_d;
`else
  assign tmo = 1'b0;
`endif
  // decode register offset, write data, read lane and error condition of the current step
  always_comb begin
    off = step_q == INIT0 || step_q == INIT3 ? 3'd3 : step_q == INIT2 ? 3'd1 : step_q == LSR ? 3'd5 : 3'd0;
    wdat = step_q == INIT0 ? 8'h80 : step_q == INIT1 ? baudDivisor[7:0] : step_q == INIT2 ? baudDivisor[15:8] : step_q == INIT3 ? lineControl & 8'h7F : byte_q;
    is_rd = step_q == LSR;
    rd_lane = addressDataIn[{off[1:0], 3'b000} +: 8];
    lsr = dataValidIn ? rd_lane : rdat_q;
    fault = (busErrorIn && (state_q == DATA || state_q == RWAIT)) || tmo;
    pick = req0Valid && req1Valid ? ptr_q : req1Valid;
  end
  // next-state: bus phase sequencing, init steps, arbitration and credit accounting
  always_comb begin
    state_d = state_q;
    step_d = step_q;
    done_d = done_q;
    err_d = err_q | fault;
    cred_d = cred_q;
    ptr_d = ptr_q;
    win_d = win_q;
    byte_d = byte_q;
    rdat_d = state_q == RWAIT && dataValidIn ? rd_lane : rdat_q;
    if (fault) begin
      state_d = IDLE;
      cred_d = 5'd0;
      step_d = step_q == THR || step_q == LSR ? ARB : step_q;
    end else begin
      case (state_q)
        IDLE: begin
          if (step_q != ARB) state_d = REQ;
          else if (req0Valid || req1Valid) begin
            win_d = pick;
            byte_d = pick ? req1Data : req0Data;
            step_d = cred_q == 5'd0 ? LSR : THR;
            state_d = REQ;
          end
        end
        REQ: state_d = transactionGrantedIn ? ADDR : REQ;
        ADDR: state_d = is_rd ? RWAIT : DATA;
        DATA: state_d = WEND;
        WEND: begin
          state_d = IDLE;
          if (step_q == THR) begin
            cred_d = cred_q - 5'd1;
            ptr_d = ~win_q;
            step_d = ARB;
          end else begin
            step_d = step_q == INIT3 ? ARB : step_t'(step_q + 3'd1);
            done_d = done_q | (step_q == INIT3);
          end
        end
        RWAIT: begin
          if (endTransactionIn) begin
            state_d = IDLE;
            cred_d = lsr[5] ? txFifoDepth : cred_q;
            step_d = lsr[5] ? THR : ARB;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // state registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      step_q <= INIT0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      cred_q <= 5'd0;
      ptr_q <= 1'b0;
      win_q <= 1'b0;
      byte_q <= 8'd0;
      rdat_q <= 8'd0;
    end else begin
      state_q <= state_d;
      step_q <= step_d;
      done_q <= done_d;
      err_q <= err_d;
      cred_q <= cred_d;
      ptr_q <= ptr_d;
      win_q <= win_d;
      byte_q <= byte_d;
      rdat_q <= rdat_d;
    end
  end
  // bus and handshake outputs decoded from the current phase
  always_comb begin
    requestTransactionOut = state_q != IDLE;
    beginTransactionOut = state_q == ADDR;
    readNWriteOut = state_q == ADDR && is_rd;
    byteEnablesOut = state_q == ADDR ? 4'b0001 << off[1:0] : 4'b0000;
    addressDataOut = state_q == ADDR ? {uartBaseAddress[31:3], off} : state_q == DATA ? {4{wdat}} : 32'd0;
    dataValidOut = state_q == DATA;
    endTransactionOut = state_q == WEND;
    req0Ack = state_q == WEND && step_q == THR && !win_q;
    req1Ack = state_q == WEND && step_q == THR && win_q;
    burstSizeOut = 8'd0;
    initDone = done_q;
    busErrorSticky = err_q;
  end
endmodule

// File: doc/uart_tx_sequencer.md
Name: uart_tx_sequencer

Overview:
Bus master that configures and feeds the bus-attached 16550-style UART slave.
- After reset it runs a fixed init sequence: divisor latch and line control.
- It then shares the UART transmitter between two byte requesters with round-robin arbitration.
- It polls the line status register (LSR) for transmit-FIFO-empty and writes bytes to the transmit holding register (THR) using a credit counter, so the transmit FIFO never overflows.
- It sits on the system bus beside the CPU and obtains the bus through the bus arbiter's request/grant pair.

Parameters:
uartBaseAddress, 32'h50000000, base byte address of the UART slave; bits [2:0] are 0.
baudDivisor, 16'd27, value written to the divisor registers DLL/DLM.
lineControl, 8'h03, final line control register (LCR) value; bit 7 forced to 0.
txFifoDepth, 5'd16, transmit credits granted per LSR[5]=1 observation (1..16).

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
req0Valid  in  1  requester 0 holds a byte
req0Data  in  8  requester 0 byte
req0Ack  out  1  one-cycle pulse: byte 0 handed to UART
req1Valid  in  1  requester 1 holds a byte
req1Data  in  8  requester 1 byte
req1Ack  out  1  one-cycle pulse: byte 1 handed to UART
requestTransactionOut  out  1  bus request to arbiter
transactionGrantedIn  in  1  bus grant
beginTransactionOut  out  1  address phase strobe
endTransactionOut  out  1  master end of a write
readNWriteOut  out  1  1=read
addressDataOut  out  32  address / write data
byteEnablesOut  out  4  one-hot lane of the addressed byte
burstSizeOut  out  8  always 0
dataValidOut  out  1  write data strobe
addressDataIn  in  32  read data
dataValidIn  in  1  read data valid
endTransactionIn  in  1  slave end of a read
busErrorIn  in  1  bus error
initDone  out  1  init sequence completed
busErrorSticky  out  1  set on any bus error; cleared only by reset

Behaviour:
- Reset: every output is 0; state INIT0; credits 0; round-robin pointer selects requester 0.
- Lane rule: offset = addr[1:0].
  - byteEnablesOut = 1 << offset.
  - Write data is replicated on all four lanes.
  - Read data is taken from lane addressDataIn[8*offset+7 -: 8].
- Bus transaction sequence, one transaction at a time:
  - REQ: requestTransactionOut=1 until transactionGrantedIn=1. requestTransactionOut stays 1 through the end of the transaction.
  - ADDR: one cycle with beginTransactionOut=1, addressDataOut=address, readNWriteOut, byteEnablesOut, burstSizeOut=0.
  - Write: DATA is one cycle with dataValidOut=1. END is one cycle with endTransactionOut=1. The request drops in the cycle after END.
  - Read: RWAIT captures the lane data when dataValidIn=1, then waits for endTransactionIn=1. The request drops in the cycle after endTransactionIn.
  - Outputs are 0 in every phase where they are not explicitly driven.
- Init writes, in order:
  1. INIT0: LCR at offset 3 = 8'h80.
  2. INIT1: DLL at offset 0 = baudDivisor[7:0].
  3. INIT2: DLM at offset 1 = baudDivisor[15:8].
  4. INIT3: LCR = lineControl & 8'h7F.
  - After INIT3, initDone=1 (held until reset) and the state goes to IDLE.
  - Requests are ignored before initDone.
- IDLE:
  - If no request is pending, stay.
  - Arbitration: when both requests are valid, the requester not served last wins. A single valid request wins outright.
  - The winner and its byte are latched at arbitration. A requester must hold Valid/Data until its Ack.
  - credits=0: read LSR (offset 5). If LSR[5]=1, credits=txFifoDepth, then write. If LSR[5]=0, return to IDLE and re-poll.
  - credits>0: write THR (offset 0) with the latched byte.
- THR write completion:
  - In the END cycle, pulse the winner's Ack.
  - Decrement credits.
  - Toggle the pointer to the other requester.
  - Return to IDLE.
- Bus error: busErrorIn=1 in any phase after ADDR, before the transaction completes.
  - Next cycle: drop all bus outputs and set busErrorSticky.
  - credits := 0.
  - Retry the same step: init steps restart that step; a THR write is re-arbitrated with no Ack issued.
- Reset mid-transaction: all outputs are 0 in the next cycle. Init restarts and initDone=0.
- Simultaneous dataValidIn and endTransactionIn in the same cycle: the data is captured and the read completes.

Optional Feature:
UART_SEQ_READ_TIMEOUT_EN:
- Defined: a 10-bit counter runs in RWAIT. On reaching 1023 cycles without endTransactionIn:
  - treat the event as a bus error (busErrorSticky=1, credits=0, retry);
  - drop requestTransactionOut.
- Not defined: RWAIT waits indefinitely; no counter is synthesised.

Test Plan:
- Reset then grant always 1 → four writes:
  - addresses base+3, base+0, base+1, base+3;
  - data 8'h80, 8'h1B, 8'h00, 8'h03 replicated on all lanes;
  - byteEnables 8, 1, 2, 8;
  - initDone=1 after the 4th END.
- req0 byte 8'h41, LSR read returns addressDataIn[15:8]=8'h20 → write base+0 with data 32'h41414141, BE 4'h1; req0Ack is exactly one pulse in the END cycle; credits=15.
- req0 and req1 held valid with 40 bytes total, LSR[5]=1 on every poll → Acks alternate 1,0,1,0… starting with req0; exactly one LSR read per 16 THR writes.
- LSR returns 8'h00 three times, then 8'h20 → four LSR reads precede the THR write; no Ack during the polling.
- busErrorIn during a THR write DATA phase → busErrorSticky=1, no Ack, next action is an LSR read, then the byte is written once.
- Macro defined, slave never ends a read → after 1023 cycles busErrorSticky=1 and the request drops. Macro undefined → the master stays in RWAIT.
